bitwise_unit_pipe: RTL and testbench

//  Parametrised, registered successor to the fixed 16-bit Not/And/Or gate arrays.

---
 rtl/bitwise_pkg.sv | 19 +
 rtl/bitwise_unit_pipe_if.sv | 35 +++
 rtl/bitwise_core.sv | 45 ++++
 rtl/bitwise_unit_pipe.sv | 100 ++++++++++
 tb/tb_bitwise_unit_pipe.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bitwise_pkg.sv
// Shared op encoding for the pipelined bitwise unit.
//   bw_op_t : 3-bit op code
//   OP_*    : op code values (NOT, AND, OR, XOR, NAND, NOR, XNOR, PASS)
package bitwise_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] bw_op_t;

  localparam bw_op_t OP_NOT  = 3'b000;
  localparam bw_op_t OP_AND  = 3'b001;
  localparam bw_op_t OP_OR   = 3'b010;
  localparam bw_op_t OP_XOR  = 3'b011;
  localparam bw_op_t OP_NAND = 3'b100;
  localparam bw_op_t OP_NOR  = 3'b101;
  localparam bw_op_t OP_XNOR = 3'b110;
  localparam bw_op_t OP_PASS = 3'b111;

endpackage

// File: rtl/bitwise_unit_pipe_if.sv
// Operand/result bus of the pipelined bitwise unit.
//   master : operand source / result consumer side
//   slave  : bitwise_unit_pipe side
//   in_*   : operand beat (valid/ready), acc_clr : accumulator clear
//   out_*  : registered result beat (valid/ready) with zero/parity flags, acc : accumulator
interface bitwise_unit_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  import bitwise_pkg::*;

  logic             in_valid;
  logic             in_ready;
  bw_op_t           in_op;
  logic             in_b_sel;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_parity;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, in_op, in_b_sel, in_a, in_b, acc_clr, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_parity, acc
  );

  modport slave (
    input  in_valid, in_op, in_b_sel, in_a, in_b, acc_clr, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_parity, acc
  );

endinterface

// File: rtl/bitwise_core.sv
// Combinational bitwise function f(op, a, b) built from per-bit gate arrays.
//   i_op       : op code
//   i_a, i_b   : operands
//   o_result_c : combinational result
module bitwise_core
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  bw_op_t           i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result_c
);

  logic [WIDTH-1:0] w_not;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;

  // One gate of each kind per bit; inverted variants are derived below.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    assign w_not[i] = ~i_a[i];
    assign w_and[i] = i_a[i] & i_b[i];
    assign w_or[i]  = i_a[i] | i_b[i];
    assign w_xor[i] = i_a[i] ^ i_b[i];
  end

  // Op select.
  always_comb begin
    o_result_c = i_a;
    case (i_op)
      OP_NOT:  o_result_c = w_not;
      OP_AND:  o_result_c = w_and;
      OP_OR:   o_result_c = w_or;
      OP_XOR:  o_result_c = w_xor;
      OP_NAND: o_result_c = ~w_and;
      OP_NOR:  o_result_c = ~w_or;
      OP_XNOR: o_result_c = ~w_xor;
      OP_PASS: o_result_c = i_a;
      default: o_result_c = i_a;
    endcase
  end

endmodule

// File: rtl/bitwise_unit_pipe.sv
// One-stage pipelined bitwise logic unit with chaining accumulator.
//   i_clk  : rising-edge clock
//   i_rst  : asynchronous active-high reset
//   bus    : slave side of bitwise_unit_pipe_if (operand beat in, result beat out,
//            acc_clr, accumulator and result flags)
module bitwise_unit_pipe
  import bitwise_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input logic                 i_clk,
  input logic                 i_rst,
  bitwise_unit_pipe_if.slave  bus
);

  bw_op_t           w_op;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_result;
  logic             w_in_ready;
  logic             w_accept;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_zero;
  logic             r_out_parity;
  logic [WIDTH-1:0] r_acc;

  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_out_data_nxt;
  logic             w_out_zero_nxt;
  logic             w_out_parity_nxt;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_op = bus.in_op;

  // b operand uses the pre-edge accumulator so chained beats see the previous result.
  assign w_b_eff    = bus.in_b_sel ? r_acc : bus.in_b;
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  bitwise_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_op       (w_op),
    .i_a        (bus.in_a),
    .i_b        (w_b_eff),
    .o_result_c (w_result)
  );

  // Next-state for output register, flags and accumulator.
  always_comb begin
    w_out_valid_nxt  = r_out_valid;
    w_out_data_nxt   = r_out_data;
    w_out_zero_nxt   = r_out_zero;
    w_out_parity_nxt = r_out_parity;
    w_acc_nxt        = r_acc;

    if (w_accept) begin
      w_out_valid_nxt  = 1'b1;
      w_out_data_nxt   = w_result;
      w_out_zero_nxt   = (w_result == '0);
      w_out_parity_nxt = ^w_result;
    end else if (bus.out_ready) begin
      w_out_valid_nxt  = 1'b0;
    end

    // Clear wins; a same-cycle beat has already computed with the pre-clear value.
    if (bus.acc_clr) begin
      w_acc_nxt = ACC_INIT;
    end else if (w_accept) begin
      w_acc_nxt = w_result;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_zero   <= 1'b1;
      r_out_parity <= 1'b0;
      r_acc        <= ACC_INIT;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_zero   <= w_out_zero_nxt;
      r_out_parity <= w_out_parity_nxt;
      r_acc        <= w_acc_nxt;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_zero   = r_out_zero;
  assign bus.out_parity = r_out_parity;
  assign bus.acc        = r_acc;

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Bench for bitwise_unit_pipe at WIDTH = 16, 1 and 37 (one instance each).
module tb_bitwise_unit_pipe;
  import bitwise_pkg::*;

  localparam int unsigned N     = 3;
  localparam logic [63:0] INIT2 = 64'h15_5555_5555;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] d_a [N];
  logic [63:0] d_b [N];
  bw_op_t      d_op [N];
  logic        d_valid [N];
  logic        d_bsel [N];
  logic        d_clr [N];
  logic        d_oready [N];

  logic [63:0] o_data [N];
  logic [63:0] o_acc [N];
  logic        o_valid [N];
  logic        o_zero [N];
  logic        o_par [N];
  logic        o_rdy [N];

  for (genvar k = 0; k < int'(N); k++) begin : g_dut
    localparam int unsigned WK = (k == 0) ? 16 : ((k == 1) ? 1 : 37);
    localparam logic [WK-1:0] IK = (k == 2) ? WK'(INIT2) : '0;

    bitwise_unit_pipe_if #(.WIDTH(WK)) bus ();

    assign bus.in_valid  = d_valid[k];
    assign bus.in_op     = d_op[k];
    assign bus.in_b_sel  = d_bsel[k];
    assign bus.in_a      = d_a[k][WK-1:0];
    assign bus.in_b      = d_b[k][WK-1:0];
    assign bus.acc_clr   = d_clr[k];
    assign bus.out_ready = d_oready[k];

    assign o_data[k]  = 64'(bus.out_data);
    assign o_acc[k]   = 64'(bus.acc);
    assign o_valid[k] = bus.out_valid;
    assign o_zero[k]  = bus.out_zero;
    assign o_par[k]   = bus.out_parity;
    assign o_rdy[k]   = bus.in_ready;

    bitwise_unit_pipe #(.WIDTH(WK), .ACC_INIT(IK)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
    );
  end

  int          checks = 0;
  int          errors = 0;
  int          cur;
  logic        m_valid;
  logic [63:0] m_acc [N];
  logic [63:0] sbq [$];

  function automatic int unsigned w_of(int k);
    return (k == 0) ? 16 : ((k == 1) ? 1 : 37);
  endfunction

  function automatic logic [63:0] mask_of(int k);
    return (64'd1 << w_of(k)) - 64'd1;
  endfunction

  function automatic logic [63:0] init_of(int k);
    return (k == 2) ? INIT2 : 64'd0;
  endfunction

  function automatic logic [63:0] f_model(bw_op_t op, logic [63:0] a, logic [63:0] b, int k);
    logic [63:0] r;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = a;
    endcase
    return r & mask_of(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s dut%0d got %h exp %h", tag, cur, got, exp);
    end
  endtask

  task automatic chk_reset_all();
    for (int k = 0; k < int'(N); k++) begin
      cur = k;
      chk("rst_out_valid", 64'(o_valid[k]), 64'd0);
      chk("rst_out_data", o_data[k], 64'd0);
      chk("rst_out_zero", 64'(o_zero[k]), 64'd1);
      chk("rst_out_parity", 64'(o_par[k]), 64'd0);
      chk("rst_acc", o_acc[k], init_of(k));
      chk("rst_in_ready", 64'(o_rdy[k]), 64'd1);
    end
  endtask

  // One cycle on the current DUT: drive, check held output, predict, clock, check state.
  task automatic step(input logic v, input bw_op_t op, input logic bsel,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic clr, input logic oready, input logic [63:0] exp);
    logic rdy;
    d_valid[cur]  = v;
    d_op[cur]     = op;
    d_bsel[cur]   = bsel;
    d_a[cur]      = a;
    d_b[cur]      = b;
    d_clr[cur]    = clr;
    d_oready[cur] = oready;
    #1;
    rdy = !m_valid || oready;
    chk("in_ready", 64'(o_rdy[cur]), 64'(rdy));
    if (m_valid) begin
      if (sbq.size() == 0) begin
        chk("scoreboard_empty", 64'(sbq.size()), 64'd1);
      end else begin
        chk("out_data", o_data[cur], sbq[0]);
        chk("out_zero", 64'(o_zero[cur]), 64'(sbq[0] == 64'd0));
        chk("out_parity", 64'(o_par[cur]), 64'(^sbq[0]));
        if (oready) void'(sbq.pop_front());
      end
    end
    if (v && rdy) begin
      sbq.push_back(exp);
      m_valid = 1'b1;
    end else if (oready) begin
      m_valid = 1'b0;
    end
    if (clr) m_acc[cur] = init_of(cur);
    else if (v && rdy) m_acc[cur] = exp;
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 64'(o_valid[cur]), 64'(m_valid));
    chk("acc", o_acc[cur], m_acc[cur]);
  endtask

  task automatic idle();
    step(1'b0, OP_NOT, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0);
  endtask

  // Chain sequence reused for the narrow and wide instances.
  task automatic run_chain();
    logic [63:0] m;
    logic [63:0] pa;
    logic [63:0] pb;
    logic [63:0] pc;
    m  = mask_of(cur);
    pa = 64'hF0F0_F0F0_F0F0 & m;
    pb = 64'hFF00_FF00_FF00 & m;
    pc = 64'h000F_000F_000F & m;
    step(1'b1, OP_XOR, 1'b1, 64'd0, 64'd0, 1'b0, 1'b1, f_model(OP_XOR, 64'd0, m_acc[cur], cur));
    step(1'b1, OP_AND, 1'b0, pa, pb, 1'b0, 1'b1, f_model(OP_AND, pa, pb, cur));
    step(1'b1, OP_OR, 1'b1, pc, 64'd0, 1'b0, 1'b1, f_model(OP_OR, pc, m_acc[cur], cur));
    step(1'b1, OP_XOR, 1'b1, m, 64'd0, 1'b0, 1'b1, f_model(OP_XOR, m, m_acc[cur], cur));
    step(1'b1, OP_NAND, 1'b1, m, 64'd0, 1'b0, 1'b0, f_model(OP_NAND, m, m_acc[cur], cur));
    step(1'b1, OP_NOT, 1'b0, pa, 64'd0, 1'b0, 1'b1, f_model(OP_NOT, pa, 64'd0, cur));
    step(1'b0, OP_NOT, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd0);
    idle();
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rs;
    rst = 1'b1;
    for (int k = 0; k < int'(N); k++) begin
      d_valid[k]  = 1'b0;
      d_op[k]     = OP_NOT;
      d_bsel[k]   = 1'b0;
      d_a[k]      = 64'd0;
      d_b[k]      = 64'd0;
      d_clr[k]    = 1'b0;
      d_oready[k] = 1'b1;
      m_acc[k]    = init_of(k);
    end
    m_valid = 1'b0;
    cur = 0;

    @(negedge clk);
    #1;
    chk_reset_all();
    rst = 1'b0;
    cur = 0;
    idle();

    // Single AND beat, then chained OR / XOR through the accumulator.
    step(1'b1, OP_AND, 1'b0, 64'hF0F0, 64'hFF00, 1'b0, 1'b1, 64'hF000);
    step(1'b1, OP_OR,  1'b1, 64'h000F, 64'h0000, 1'b0, 1'b1, 64'hF00F);
    step(1'b1, OP_XOR, 1'b1, 64'hFFFF, 64'h0000, 1'b0, 1'b1, 64'h0FF0);
    idle();

    // Back-pressure: held result stays stable and the next beat waits.
    step(1'b1, OP_PASS, 1'b0, 64'h1234, 64'h0000, 1'b0, 1'b0, 64'h1234);
    for (int i = 0; i < 3; i++)
      step(1'b1, OP_NOT, 1'b0, 64'h5555, 64'h0000, 1'b0, 1'b0, 64'hAAAA);
    step(1'b1, OP_NOT, 1'b0, 64'h5555, 64'h0000, 1'b0, 1'b1, 64'hAAAA);

    // Full throughput over all ops with random operands.
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom(), $urandom()} & mask_of(cur);
      rb = {$urandom(), $urandom()} & mask_of(cur);
      rs = 1'(i % 2);
      step(1'b1, bw_op_t'(i), rs, ra, rb, 1'b0, 1'b1,
           f_model(bw_op_t'(i), ra, rs ? m_acc[cur] : rb, cur));
    end
    idle();

    // Clear concurrent with an accepted beat that reads the pre-clear accumulator.
    step(1'b1, OP_PASS, 1'b0, 64'h00FF, 64'h0000, 1'b0, 1'b1, 64'h00FF);
    step(1'b1, OP_NOR,  1'b1, 64'h0000, 64'h0000, 1'b1, 1'b1, 64'hFF00);
    idle();

    // Async reset mid-cycle while a result is held.
    step(1'b1, OP_PASS, 1'b0, 64'hABCD, 64'h0000, 1'b0, 1'b0, 64'hABCD);
    d_valid[cur] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_all();
    cur = 0;
    #1;
    rst = 1'b0;
    sbq.delete();
    m_valid = 1'b0;
    for (int k = 0; k < int'(N); k++) m_acc[k] = init_of(k);
    @(negedge clk);
    d_oready[cur] = 1'b1;
    idle();

    // Narrow and wide instances.
    cur = 1;
    run_chain();
    cur = 2;
    run_chain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
